// File: rtl/stream_credit_tx_pkg.sv
// Shared types and helpers for the credit-based stream transmitter.
package stream_credit_tx_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    function automatic int cnt_width(input int credit_max);
        return $clog2(credit_max + 1);
    endfunction

endpackage

// File: rtl/stream_credit_tx_credit_counter.sv
// Credit counter: load on init, count sends/returns, saturate and flag overflow.
module credit_counter
    import stream_credit_tx_pkg::*;
#(
    parameter int CREDIT_MAX = 4,
    parameter int CNT_WIDTH  = cnt_width(CREDIT_MAX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 err_o
);

    localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(CREDIT_MAX);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (load_i) begin
            cnt_d = MAX;
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - ONE;
        end else if (inc_i && !dec_i) begin
            // A return with nothing outstanding is a protocol error.
            if (cnt_q == MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-based transmitter: valid/ready in, registered valid-only link out.
module stream_credit_tx
    import stream_credit_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CREDIT_MAX = 4,
    localparam int CNT_WIDTH = cnt_width(CREDIT_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  tx_valid_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  credit_ret_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [CNT_WIDTH-1:0]  credit_cnt_o,
    output logic                  err_o
);

    localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(CREDIT_MAX);

    state_e                state_q, state_d;
    logic                  hold_v_q, hold_v_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  txv_q, txv_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  done_q, done_d;

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  accept;
    logic                  cand_v;
    logic [DATA_WIDTH-1:0] cand;
    logic                  has_credit;
    logic                  send;
    logic                  load;
    logic                  inc;

    assign s_ready_o  = (state_q == ST_RUN) && !hold_v_q;
    assign accept     = s_valid_i && s_ready_o;
    assign cand_v     = hold_v_q || accept;
    assign cand       = hold_v_q ? hold_q : s_data_i;
    assign has_credit = (cnt != '0);
    assign send       = cand_v && has_credit;
    assign load       = (state_q == ST_INIT);
    assign inc        = credit_ret_i && (state_q != ST_INIT);

    always_comb begin
        state_d  = state_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        txv_d    = send;
        txd_d    = txd_q;
        done_d   = 1'b0;
        if (send) begin
            txd_d = cand;
        end
        if (send && hold_v_q) begin
            hold_v_d = 1'b0;
        end
        // Accept only happens with hold empty, so the stall slot is free.
        if (accept && !has_credit) begin
            hold_v_d = 1'b1;
            hold_d   = s_data_i;
        end
        unique case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!hold_v_q && cnt == MAX) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            txv_q    <= txv_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
        end
    end

    credit_counter #(
        .CREDIT_MAX (CREDIT_MAX),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_credit (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .dec_i  (send),
        .inc_i  (inc),
        .cnt_o  (cnt),
        .err_o  (err_o)
    );

    assign tx_valid_o   = txv_q;
    assign tx_data_o    = txd_q;
    assign flush_done_o = done_q;
    assign credit_cnt_o = cnt;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Directed table-driven bench for stream_credit_tx (CREDIT_MAX=4).
module tb_stream_credit_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_data_i;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        credit_ret_i;
    logic        flush_i;
    logic        flush_done_o;
    logic [2:0]  credit_cnt_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    stream_credit_tx #(
        .DATA_WIDTH (32),
        .CREDIT_MAX (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .credit_ret_i (credit_ret_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .credit_cnt_o (credit_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] d;
        logic        ret;
        logic        fl;
        logic        rdy;
        logic        txv;
        logic [31:0] txd;
        logic [2:0]  cnt;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] d,
                         input logic ret, input logic fl);
        rst_n        = rst;
        s_valid_i    = v;
        s_data_i     = d;
        credit_ret_i = ret;
        flush_i      = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic rst, input logic v, input logic [31:0] d,
        input logic ret, input logic fl, input logic rdy, input logic txv,
        input logic [31:0] txd, input logic [2:0] cnt, input logic done,
        input logic err);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.ret = ret; t.fl = fl;
        t.rdy = rdy; t.txv = txv; t.txd = txd; t.cnt = cnt;
        t.done = done; t.err = err;
        return t;
    endfunction

    initial begin
        bit seen;
        //            rst v d         ret fl  rdy txv txd     cnt dn er
        tbl.push_back(mk(0, 0, 32'h0,  0, 0,  0, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0,  0, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 1,  1, 0, 32'h0,  4, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA0, 0, 0,  1, 1, 32'hA0, 3, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 0, 0,  1, 1, 32'hA1, 2, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA2, 0, 0,  1, 1, 32'hA2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA3, 0, 0,  1, 1, 32'hA3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA4, 0, 0,  0, 0, 32'hA3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hBAD, 0, 0, 0, 0, 32'hA3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  0, 0, 32'hA3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 1, 32'hA4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  1, 0, 32'hA4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  1, 0, 32'hA4, 2, 0, 0));
        tbl.push_back(mk(1, 1, 32'hB0, 1, 0,  1, 1, 32'hB0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  1, 0, 32'hB0, 3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  1, 0, 32'hB0, 4, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  1, 0, 32'hB0, 4, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 0, 32'hB0, 4, 0, 1));
        tbl.push_back(mk(1, 1, 32'hC0, 0, 0,  1, 1, 32'hC0, 3, 0, 1));
        tbl.push_back(mk(1, 1, 32'hC1, 0, 0,  1, 1, 32'hC1, 2, 0, 1));
        tbl.push_back(mk(1, 1, 32'hC2, 0, 0,  1, 1, 32'hC2, 1, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,  0, 1,  0, 0, 32'hC2, 1, 0, 1));
        tbl.push_back(mk(1, 1, 32'hD0, 1, 0,  0, 0, 32'hC2, 2, 0, 1));
        tbl.push_back(mk(1, 1, 32'hD0, 1, 1,  0, 0, 32'hC2, 3, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,  1, 0,  0, 0, 32'hC2, 4, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 0, 32'hC2, 4, 1, 1));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 0, 32'hC2, 4, 0, 1));
        tbl.push_back(mk(1, 1, 32'hE0, 0, 0,  1, 1, 32'hE0, 3, 0, 1));
        tbl.push_back(mk(1, 1, 32'hE1, 0, 0,  1, 1, 32'hE1, 2, 0, 1));
        tbl.push_back(mk(1, 1, 32'hE2, 0, 0,  1, 1, 32'hE2, 1, 0, 1));
        tbl.push_back(mk(1, 1, 32'hE3, 0, 0,  1, 1, 32'hE3, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'hE4, 0, 0,  0, 0, 32'hE3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'hE5, 1, 0,  0, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 0, 32'h0,  4, 0, 0));
        tbl.push_back(mk(1, 1, 32'hF0, 0, 0,  1, 1, 32'hF0, 3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0, 0,  1, 0, 32'hF0, 3, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].ret, tbl[i].fl);
            chk($sformatf("v%0d.ready", i), 32'(s_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("v%0d.txv", i), 32'(tx_valid_o), 32'(tbl[i].txv));
            chk($sformatf("v%0d.txd", i), tx_data_o, tbl[i].txd);
            chk($sformatf("v%0d.cnt", i), 32'(credit_cnt_o),
                32'(tbl[i].cnt));
            chk($sformatf("v%0d.done", i), 32'(flush_done_o),
                32'(tbl[i].done));
            chk($sformatf("v%0d.err", i), 32'(err_o), 32'(tbl[i].err));
        end

        // Flush while a stalled word is held: hold drains first.
        drive(1, 1, 32'h60, 0, 0);
        drive(1, 1, 32'h61, 0, 0);
        drive(1, 1, 32'h62, 0, 0);
        chk("g.cnt0", 32'(credit_cnt_o), 32'd0);
        drive(1, 1, 32'h63, 0, 0);
        chk("g.held_ready", 32'(s_ready_o), 32'd0);
        drive(1, 1, 32'h99, 0, 1);
        chk("g.flush_txv", 32'(tx_valid_o), 32'd0);
        drive(1, 1, 32'h99, 1, 0);
        chk("g.ret_cnt", 32'(credit_cnt_o), 32'd1);
        drive(1, 1, 32'h99, 0, 0);
        chk("g.hold_txv", 32'(tx_valid_o), 32'd1);
        chk("g.hold_txd", tx_data_o, 32'h63);
        chk("g.hold_cnt", 32'(credit_cnt_o), 32'd0);
        chk("g.flush_ready", 32'(s_ready_o), 32'd0);

        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(1, 1, 32'h99, credit_cnt_o != 3'd4, 0);
            if (flush_done_o) seen = 1;
            else if (tx_valid_o) begin
                chk("g.no_send", 32'(tx_valid_o), 32'd0);
            end
        end
        chk("g.done_seen", 32'(seen), 32'd1);
        chk("g.done_cnt", 32'(credit_cnt_o), 32'd4);
        chk("g.done_ready", 32'(s_ready_o), 32'd1);
        drive(1, 0, 32'h0, 0, 0);
        chk("g.done_pulse", 32'(flush_done_o), 32'd0);
        chk("g.err_clear", 32'(err_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_credit_tx.md
Name: stream_credit_tx

Overview:
- Credit-based transmitter that feeds a remote SRAM stream FIFO across a valid-only link that has no backpressure.
- Upstream side is a valid/ready stream. Downstream side emits one registered word per credit.
- Credits return one per cycle when the remote FIFO pops.
- Holds at most one stalled word locally, supports a flush/drain handshake, and flags credit overflow.

Parameters:
- DATA_WIDTH, 32, payload width.
- CREDIT_MAX, 4, remote FIFO depth and initial credit count; must be >= 1.
- CNT_WIDTH, $clog2(CREDIT_MAX+1), localparam; width of the credit counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- s_valid_i  input  1  upstream word valid.
- s_ready_o  output  1  upstream ready.
- s_data_i  input  DATA_WIDTH  upstream word.
- tx_valid_o  output  1  link word valid, registered, no ready.
- tx_data_o  output  DATA_WIDTH  link word, registered.
- credit_ret_i  input  1  one credit returned this cycle.
- flush_i  input  1  request to drain until all credits are home.
- flush_done_o  output  1  single-cycle pulse when the drain completes.
- credit_cnt_o  output  CNT_WIDTH  current credit count (registered).
- err_o  output  1  sticky credit-overflow flag.

Behaviour:
- Reset: when rst_n=0 at a posedge, the next state is:
  - state=INIT
  - tx_valid_o=0, tx_data_o=0
  - hold_v=0, hold data=0
  - credit count=0
  - flush_done_o=0, err_o=0
  - s_ready_o=0 (it is decoded from state and hold_v).
- Reset asserted mid-operation discards any held word and the outstanding-credit view.
- States: INIT, RUN, FLUSH, 2-bit encoding.
  - INIT lasts one cycle. It loads credit=CREDIT_MAX, goes to RUN, and ignores credit_ret_i and flush_i.
  - RUN with flush_i=1 goes to FLUSH. flush_i is sampled only in RUN.
  - FLUSH goes to RUN when hold_v=0 and credit==CREDIT_MAX, using registered values. flush_done_o=1 in the following cycle only.
- s_ready_o = (state==RUN) && !hold_v. There is no combinational path from s_valid_i or credit_ret_i.
- Candidate word each cycle:
  - the hold entry if hold_v=1;
  - otherwise s_data_i when s_valid_i && s_ready_o.
- Send: fires when a candidate exists and registered credit > 0.
  - tx_valid_o<=1 and tx_data_o<=candidate on the next edge.
  - Latency from accept to tx_valid_o is 1 cycle.
  - Otherwise tx_valid_o<=0 and tx_data_o holds its value.
- Stall: an accepted input word with credit==0 is written into hold.
  - hold_v clears when the hold entry is sent.
  - The hold entry always goes before new input; ordering is strictly preserved.
- Credit update: next = cnt - send + credit_ret_i.
  - A credit returned in the same cycle is not usable until the next cycle.
  - Send and return together leave the count unchanged.
- Overflow: credit_ret_i=1 with cnt==CREDIT_MAX and no send:
  - count saturates at CREDIT_MAX;
  - err_o<=1 and stays set until reset.
- Underflow cannot occur by construction; send requires cnt>0.
- FLUSH: s_ready_o=0. A pending hold word is still sent when a credit is available, and returns are still counted.
- credit_cnt_o = registered count.

Decomposition:
- Shared package holds:
  - state encodings ST_INIT=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2;
  - the credit-width helper ($clog2(CREDIT_MAX+1)).
- One natural sub-module, credit_counter: load, dec, inc, saturation, overflow flag.

Test Plan:
All scenarios use CREDIT_MAX=4, DATA_WIDTH=32.
1. Release rst_n → first cycle: s_ready_o=0, credit_cnt_o=0. Next cycle: credit_cnt_o=4, s_ready_o=1.
2. Push 0xA0..0xA3 back-to-back with no returns → tx_valid_o high for 4 consecutive cycles, 1 cycle after each accept, data in order; credit_cnt_o goes 3,2,1,0. Push 0xA4 → accepted into hold, then s_ready_o=0, tx_valid_o=0.
3. From state 2, pulse credit_ret_i for 1 cycle → credit_cnt_o=1 the next cycle. The following edge gives tx_data_o=0xA4 with tx_valid_o=1; credit_cnt_o=0, s_ready_o=1.
4. At credit_cnt_o=2, send and credit_ret_i in the same cycle → credit_cnt_o stays 2. At cnt=4 while idle, credit_ret_i=1 → cnt stays 4, err_o=1 and persists until rst_n=0.
5. With 3 credits outstanding, pulse flush_i → s_ready_o=0 while s_valid_i=1 is ignored. Return 3 credits over 3 cycles → flush_done_o is a single pulse after cnt==4, then s_ready_o=1.
6. Hold a word with cnt=0, then assert rst_n=0 for 1 cycle → hold is discarded and no tx_valid_o. INIT follows, then cnt=4 and normal operation.
